// File: rtl/pio_out_pulse.sv
// rtl/pio_out_pulse.sv - Avalon-MM output PIO with atomic set/clear and a timed pulse-inversion engine.
// Optional square-wave repeat mode: define PIO_OUT_PULSE_REPEAT_EN.
module pio_out_pulse #(
    parameter int                    DATA_WIDTH  = 4,
    parameter int                    CNT_W       = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_LEN      = 3'd1;
    localparam logic [2:0] A_IRQ_MASK = 3'd2;
    localparam logic [2:0] A_STATUS   = 3'd3;
    localparam logic [2:0] A_OUTSET   = 3'd4;
    localparam logic [2:0] A_OUTCLEAR = 3'd5;
    localparam logic [2:0] A_PULSE    = 3'd6;
`ifdef PIO_OUT_PULSE_REPEAT_EN
    localparam logic [2:0] A_CTRL     = 3'd7;
`endif

`ifdef PIO_OUT_PULSE_REPEAT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE} state_t;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] w_mask_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CNT_W-1:0]      r_pulse_len;
    logic                  r_irq_mask;
    logic                  r_done;
    logic                  r_repeat;
    logic [31:0]           r_readdata;
    logic [31:0]           w_rdata;
    logic                  w_wr;
    logic                  w_busy;
    logic                  w_set_done;
    logic                  w_len_zero;
    logic [CNT_W-1:0]      w_len_m1;
    logic                  w_unused;

    assign w_wr       = chipselect & ~write_n;
    assign w_busy     = (r_state != ST_IDLE);
    assign w_len_zero = (r_pulse_len == '0);
    assign w_len_m1   = r_pulse_len - CNT_W'(1);
    assign w_unused   = ^writedata;

    assign out_port = r_data ^ ((r_state == ST_ACTIVE) ? r_mask : '0);
    assign irq      = r_done & r_irq_mask;
    assign readdata = r_readdata;

`ifndef PIO_OUT_PULSE_REPEAT_EN
    assign r_repeat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        w_set_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr && address == A_PULSE) begin
                    if (w_len_zero) begin
                        w_set_done = 1'b1;
                    end else begin
                        w_mask_nxt  = writedata[DATA_WIDTH-1:0];
                        w_cnt_nxt   = w_len_m1;
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (r_cnt == '0) begin
                    w_set_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
`ifdef PIO_OUT_PULSE_REPEAT_EN
                    // A zero length programmed mid-wave stops the wave rather than wrapping the counter.
                    if (r_repeat && !w_len_zero) begin
                        w_cnt_nxt   = w_len_m1;
                        w_state_nxt = ST_GAP;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
`ifdef PIO_OUT_PULSE_REPEAT_EN
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    if (r_repeat && !w_len_zero) begin
                        w_cnt_nxt   = w_len_m1;
                        w_state_nxt = ST_ACTIVE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            A_DATA:     w_rdata = 32'(r_data);
            A_LEN:      w_rdata = 32'(r_pulse_len);
            A_IRQ_MASK: w_rdata = {31'b0, r_irq_mask};
            A_STATUS:   w_rdata = {30'b0, r_done, w_busy};
`ifdef PIO_OUT_PULSE_REPEAT_EN
            A_CTRL:     w_rdata = {31'b0, r_repeat};
`endif
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= RESET_VALUE;
            r_pulse_len <= '0;
            r_irq_mask  <= 1'b0;
            r_done      <= 1'b0;
            r_readdata  <= '0;
`ifdef PIO_OUT_PULSE_REPEAT_EN
            r_repeat    <= 1'b0;
`endif
        end else begin
            r_readdata <= w_rdata;
            // A completion on the same edge as a STATUS write keeps done set.
            r_done     <= w_set_done | (r_done & ~(w_wr && address == A_STATUS));
            if (w_wr) begin
                case (address)
                    A_DATA:     r_data      <= writedata[DATA_WIDTH-1:0];
                    A_LEN:      r_pulse_len <= writedata[CNT_W-1:0];
                    A_IRQ_MASK: r_irq_mask  <= writedata[0];
                    A_OUTSET:   r_data      <= r_data | writedata[DATA_WIDTH-1:0];
                    A_OUTCLEAR: r_data      <= r_data & ~writedata[DATA_WIDTH-1:0];
`ifdef PIO_OUT_PULSE_REPEAT_EN
                    A_CTRL:     r_repeat    <= writedata[0];
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pio_out_pulse.sv
// tb/tb_pio_out_pulse.sv - Vector table, directed corner sequences and random traffic against a reference model.
module tb_pio_out_pulse;
    localparam int DW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic          irq;

    int total = 0;
    int bad   = 0;

    pio_out_pulse #(.DATA_WIDTH(DW), .CNT_W(CW), .RESET_VALUE('0)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: a pulse is "cycles of inversion still owed", a gap is "cycles of plain data owed".
    int          m_data, m_len, m_imask, m_done, m_rep, m_mask, m_left, m_gap;
    logic [31:0] m_rd;

    task automatic model_step();
        bit wr;
        bit set_done;
        int busy;
        wr = chipselect && !write_n;
        if (reset) begin
            m_data = 0; m_len = 0; m_imask = 0; m_done = 0; m_rep = 0;
            m_mask = 0; m_left = 0; m_gap = 0; m_rd = 0;
            return;
        end
        busy = (m_left > 0 || m_gap > 0) ? 1 : 0;
        case (address)
            3'd0: m_rd = m_data;
            3'd1: m_rd = m_len;
            3'd2: m_rd = m_imask;
            3'd3: m_rd = m_done * 2 + busy;
            3'd7: m_rd = m_rep;
            default: m_rd = 0;
        endcase
        set_done = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                set_done = 1;
                if (m_rep != 0 && m_len > 0) m_gap = m_len;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0 && m_rep != 0 && m_len > 0) m_left = m_len;
        end else if (wr && address == 3'd6) begin
            if (m_len > 0) begin
                m_left = m_len;
                m_mask = writedata % 16;
            end else begin
                set_done = 1;
            end
        end
        if (wr) begin
            case (address)
                3'd0: m_data = writedata % 16;
                3'd1: m_len = writedata % 65536;
                3'd2: m_imask = writedata % 2;
                3'd3: m_done = 0;
                3'd4: m_data = m_data | (writedata % 16);
                3'd5: m_data = m_data & (15 - (writedata % 16));
`ifdef PIO_OUT_PULSE_REPEAT_EN
                3'd7: m_rep = writedata % 2;
`endif
                default: ;
            endcase
        end
        if (set_done) m_done = 1;
    endtask

    task automatic cycle(input bit r, input bit cs, input bit wr, input logic [2:0] a, input logic [31:0] d);
        reset      = r;
        chipselect = cs;
        write_n    = !wr;
        address    = a;
        writedata  = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          cs;
        bit          wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  eo;
        bit          ei;
        bit          crd;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit rst, bit cs, bit wr, logic [2:0] a, logic [31:0] d,
                               logic [3:0] eo, bit ei, bit crd, logic [31:0] erd);
        vec_t x;
        x.rst = rst; x.cs = cs; x.wr = wr; x.a = a; x.d = d;
        x.eo = eo; x.ei = ei; x.crd = crd; x.erd = erd;
        return x;
    endfunction

    initial begin
        @(negedge clk);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("reset out_port", 32'(out_port), 0);
        chk("reset irq", 32'(irq), 0);
        chk("reset readdata", readdata, 0);

        for (int a = 0; a < 8; a++) tbl.push_back(v(0, 1, 0, 3'(a), 0, 0, 0, 1, 0));
        // DATA / OUTSET / OUTCLEAR
        tbl.push_back(v(0, 1, 1, 0, 5,    5, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 4, 2,    7, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 5, 4,    3, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0,    3, 0, 1, 3));
        // 3-cycle pulse of 0x9 with irq
        tbl.push_back(v(0, 1, 1, 1, 3,    3, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 2, 1,    3, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0,    0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 6, 9,    9, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 3, 0,    9, 0, 1, 1));
        tbl.push_back(v(0, 1, 0, 3, 0,    9, 0, 1, 1));
        tbl.push_back(v(0, 1, 0, 3, 0,    0, 1, 1, 1));
        tbl.push_back(v(0, 1, 0, 3, 0,    0, 1, 1, 2));
        tbl.push_back(v(0, 1, 1, 3, 0,    0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 3, 0,    0, 0, 1, 0));
        // PULSE while busy is ignored
        tbl.push_back(v(0, 1, 1, 1, 5,    0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 6, 1,    1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,    1, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 6, 'hF,  1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,    1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,    1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,    0, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 3, 0,    0, 0, 0, 0));
        // zero-length pulse only sets done
        tbl.push_back(v(0, 1, 1, 1, 0,    0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 6, 'hF,  0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 3, 0,    0, 1, 1, 2));
        tbl.push_back(v(0, 1, 1, 3, 0,    0, 0, 0, 0));
        // completion and STATUS clear on the same edge: set wins
        tbl.push_back(v(0, 1, 1, 1, 1,    0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 6, 2,    2, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 3, 0,    0, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 3, 0,    0, 0, 0, 0));
        // write without chipselect is ignored
        tbl.push_back(v(0, 0, 1, 0, 'hF,  0, 0, 0, 0));
        // reset in the middle of a 10-cycle pulse
        tbl.push_back(v(0, 1, 1, 1, 10,   0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 3,    3, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 6, 'hF,  'hC, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0,    0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 3, 0,    0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 1, 0,    0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 2, 0,    0, 0, 1, 0));

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].cs, tbl[i].wr, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d out_port", i), 32'(out_port), 32'(tbl[i].eo));
            chk($sformatf("vec%0d irq", i), 32'(irq), 32'(tbl[i].ei));
            if (tbl[i].crd) chk($sformatf("vec%0d readdata", i), readdata, tbl[i].erd);
        end

`ifdef PIO_OUT_PULSE_REPEAT_EN
        // Square wave with PULSE_LEN=2, stopped by clearing CTRL during an active phase
        cycle(0, 1, 1, 1, 2);
        cycle(0, 1, 1, 7, 1);
        cycle(0, 1, 1, 6, 5);
        chk("repeat i0", 32'(out_port), 5);
        for (int i = 1; i < 13; i++) begin
            logic [3:0] exp;
            if (i == 8) cycle(0, 1, 1, 7, 0);
            else        cycle(0, 0, 0, 0, 0);
            exp = (i < 10 && ((i / 2) % 2 == 0)) ? 4'h5 : 4'h0;
            chk($sformatf("repeat i%0d", i), 32'(out_port), 32'(exp));
        end
        cycle(0, 1, 0, 3, 0);
        chk("repeat status", readdata, 2);
        cycle(1, 0, 0, 0, 0);
`else
        cycle(0, 1, 1, 7, 1);
        cycle(0, 1, 0, 7, 0);
        chk("addr7 reads 0", readdata, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            bit          r, cs, wr;
            logic [2:0]  a;
            logic [31:0] d;
            r  = ($urandom_range(0, 299) == 0);
            cs = ($urandom_range(0, 3) != 0);
            wr = $urandom_range(0, 1) == 1;
            a  = 3'($urandom_range(0, 7));
            d  = (a == 3'd1) ? 32'($urandom_range(0, 6)) : $urandom;
            cycle(r, cs, wr, a, d);
            chk($sformatf("rand%0d out_port", n), 32'(out_port),
                32'((m_data ^ ((m_left > 0) ? m_mask : 0)) % 16));
            chk($sformatf("rand%0d irq", n), 32'(irq), 32'(m_done & m_imask));
            chk($sformatf("rand%0d readdata", n), readdata, m_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
